// File: rtl/soc_sysinfo_pkg.sv
// Shared constants for the system-info register block: word map, CTRL bits, INFO fields.
// Latency: n/a (constants and a pure byte-merge helper).
// Backpressure: n/a.
package soc_sysinfo_pkg;

  // Word addresses
  localparam logic [3:0] ADDR_ID       = 4'd0;
  localparam logic [3:0] ADDR_TS       = 4'd1;
  localparam logic [3:0] ADDR_INFO     = 4'd2;
  localparam logic [3:0] ADDR_CTRL     = 4'd3;
  localparam logic [3:0] ADDR_CNT_LO   = 4'd4;
  localparam logic [3:0] ADDR_CNT_HI   = 4'd5;
  localparam logic [3:0] ADDR_PERIOD   = 4'd6;
  localparam logic [3:0] ADDR_STATUS   = 4'd7;
  localparam logic [3:0] ADDR_SCRATCH0 = 4'd8;

  // CTRL bit positions
  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  // INFO field LSB positions
  localparam int INFO_VER_LSB  = 16;
  localparam int INFO_NSCR_LSB = 8;
  localparam int INFO_CNTW_LSB = 0;

  // Replace only the bytes of old_v whose byte-enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_sysinfo_ctr.sv
// Free-running uptime counter with synchronous clear and a high-word shadow latch.
// Latency: clear/increment/latch take effect on the next rising edge.
// Backpressure: none; control inputs are honoured every cycle.
module soc_sysinfo_ctr
  import soc_sysinfo_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        latch_i,
  output logic [31:0] cnt_lo_o,
  output logic [31:0] shadow_o
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      hi_ext;

  // Next counter value: clear beats increment; natural wrap at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Zero-extended upper word, captured when the low word is read.
  always_comb begin
    hi_ext = '0;
    hi_ext[HI_W-1:0] = cnt_q[CNT_W-1:32];
    shadow_d = latch_i ? hi_ext : shadow_q;
  end

  // Counter and shadow state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_lo_o = cnt_q[31:0];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/soc_sysinfo.sv
// Avalon-MM system-info block: ID/build/info words, uptime counter, heartbeat tick, scratch.
// Latency: readdata/readdatavalid registered, exactly 1 cycle after read; irq registered.
// Backpressure: none; no wait states, every read/write strobe is accepted.
module soc_sysinfo
  import soc_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h6379_7378,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter logic [15:0] VERSION     = 16'h0001,
  parameter int          NUM_SCRATCH = 2,
  parameter int          CNT_W       = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        irq
);

  logic        rd_en, wr_en;
  logic        ctrl_wr, period_wr, status_w1c;
  logic        ctr_clr, ctr_latch;
  logic [31:0] cnt_lo, shadow;
  logic [31:0] info_word, rd_mux;

  logic        cnt_en_q, cnt_en_d, irq_en_q, irq_en_d;
  logic [31:0] period_q, period_d;
  logic [31:0] tick_q, tick_d;
  logic        tick_hit;
  logic        status_q, status_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  // A simultaneous read and write performs only the read.
  assign rd_en      = read;
  assign wr_en      = write & ~read;
  assign ctrl_wr    = wr_en && (address == ADDR_CTRL) && byteenable[0];
  assign ctr_clr    = ctrl_wr && writedata[CTRL_CLR];
  assign period_wr  = wr_en && (address == ADDR_PERIOD);
  assign status_w1c = wr_en && (address == ADDR_STATUS) && byteenable[0] && writedata[0];
  assign ctr_latch  = rd_en && (address == ADDR_CNT_LO);

  soc_sysinfo_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .en_i     (cnt_en_q),
    .clr_i    (ctr_clr),
    .latch_i  (ctr_latch),
    .cnt_lo_o (cnt_lo),
    .shadow_o (shadow)
  );

  // Constant INFO word assembled from the build parameters.
  always_comb begin
    info_word = '0;
    info_word[INFO_VER_LSB  +: 16] = VERSION;
    info_word[INFO_NSCR_LSB +: 8]  = 8'(NUM_SCRATCH);
    info_word[INFO_CNTW_LSB +: 8]  = 8'(CNT_W);
  end

  // Read data mux; unmapped words read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:     rd_mux = SYSTEM_ID;
      ADDR_TS:     rd_mux = TIMESTAMP;
      ADDR_INFO:   rd_mux = info_word;
      ADDR_CTRL: begin
        rd_mux[CTRL_CNT_EN] = cnt_en_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_CNT_LO: rd_mux = cnt_lo;
      ADDR_CNT_HI: rd_mux = shadow;
      ADDR_PERIOD: rd_mux = period_q;
      ADDR_STATUS: rd_mux[0] = status_q;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == ADDR_SCRATCH0 + 4'(i)) rd_mux = scratch_q[i];
        end
      end
    endcase
  end

  // Read response: capture on read, hold otherwise.
  always_comb begin
    rdata_d  = rd_en ? rd_mux : rdata_q;
    rvalid_d = rd_en;
  end

  // CTRL enables and PERIOD register updates.
  always_comb begin
    cnt_en_d = cnt_en_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      cnt_en_d = writedata[CTRL_CNT_EN];
      irq_en_d = writedata[CTRL_IRQ_EN];
    end
    period_d = period_wr ? be_merge(period_q, writedata, byteenable) : period_q;
  end

  // Heartbeat tick: clear or any PERIOD write restarts it; PERIOD=0 stops it.
  always_comb begin
    tick_d   = tick_q;
    tick_hit = 1'b0;
    if (ctr_clr || period_wr) begin
      tick_d = '0;
    end else if ((period_q != '0) && cnt_en_q) begin
      if (tick_q == period_q - 32'd1) begin
        tick_d   = '0;
        tick_hit = 1'b1;
      end else begin
        tick_d = tick_q + 32'd1;
      end
    end
  end

  // Sticky status with set-over-clear priority, and the registered interrupt.
  always_comb begin
    status_d = status_q;
    if (tick_hit)        status_d = 1'b1;
    else if (status_w1c) status_d = 1'b0;
    irq_d = status_q & irq_en_q;
  end

  // Byte-enabled scratch register writes.
  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (wr_en && (address == ADDR_SCRATCH0 + 4'(i))) begin
        scratch_d[i] = be_merge(scratch_q[i], writedata, byteenable);
      end
    end
  end

  // All block state, synchronously reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_en_q <= 1'b1;
      irq_en_q <= 1'b0;
      period_q <= '0;
      tick_q   <= '0;
      status_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      cnt_en_q <= cnt_en_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign irq           = irq_q;

endmodule

// File: doc/soc_sysinfo.md
SOC_SYSINFO -- requirements
Module: soc_sysinfo

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 32'h6379_7378, meaning the value returned at ID word.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h0, meaning the build time value returned at TIMESTAMP word.
REQ-003 SHALL have parameter VERSION, default 16'h0001, meaning the block revision.
REQ-004 SHALL have parameter NUM_SCRATCH, default 2, range 1..8, meaning the count of RW scratch words.
REQ-005 SHALL have parameter CNT_W, default 48, range 33..64, meaning the uptime counter width.
REQ-006 SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-008 SHALL have port address, input, 4 bits, the word address.
REQ-009 SHALL have ports read and write, input, 1 bit each, the Avalon-MM strobes.
REQ-010 SHALL have ports writedata, input, 32 bits, and byteenable, input, 4 bits.
REQ-011 SHALL have ports readdata, output, 32 bits, and readdatavalid, output, 1 bit.
REQ-012 SHALL have port irq, output, 1 bit, the level heartbeat interrupt.

Function
REQ-013 SHALL decode word addresses as follows: 0 ID (RO); 1 TIMESTAMP (RO); 2 INFO (RO: [31:16] VERSION, [15:8] NUM_SCRATCH, [7:0] CNT_W); 3 CTRL; 4 CNT_LO; 5 CNT_HI; 6 PERIOD; 7 STATUS; 8..8+NUM_SCRATCH-1 SCRATCH.
REQ-014 SHALL return readdata exactly 1 cycle after read, with readdatavalid high for that single cycle; readdata SHALL hold its value when idle, and there are no wait states.
REQ-015 SHALL return 0 on reads of unmapped addresses and SHALL ignore writes to RO or unmapped addresses.
REQ-016 SHALL perform the read and ignore the write when read and write are asserted in the same cycle.
REQ-017 CTRL SHALL be: bit0 cnt_en (RW), bit1 irq_en (RW), bit2 clr (write-1 pulse, reads 0); CTRL writes use byteenable[0] only.
REQ-018 The uptime counter SHALL increment by 1 per cycle while cnt_en=1 and SHALL wrap from 2^CNT_W-1 to 0.
REQ-019 Writing clr=1 SHALL zero the counter and the tick counter on the next edge; clr SHALL win over increment.
REQ-020 A CNT_LO read SHALL return counter[31:0] as sampled in the read cycle and SHALL, in the same cycle, latch counter[CNT_W-1:32], zero-extended, into a shadow register.
REQ-021 A CNT_HI read SHALL return the shadow value; the shadow is unchanged by CNT_HI reads.
REQ-022 PERIOD and SCRATCH writes SHALL update only the bytes enabled by byteenable.
REQ-023 When PERIOD≠0, cnt_en=1 and clr is not active, the tick counter SHALL increment each cycle; on reaching PERIOD-1 it SHALL wrap to 0 and set STATUS bit0.
REQ-024 PERIOD=0 SHALL disable ticking; any PERIOD write SHALL zero the tick counter.
REQ-025 STATUS bit0 SHALL be write-1-to-clear; when a set and a clear occur in the same cycle, the set SHALL win.
REQ-026 irq SHALL be registered as STATUS bit0 AND irq_en, asserting 1 cycle after the status bit sets.

Reset
REQ-027 On reset_n=0 at an edge: counter=0, shadow=0, tick=0, CTRL=0x1 (counter running, irq off), PERIOD=0, STATUS=0, SCRATCH=0, readdata=0, readdatavalid=0, irq=0.
REQ-028 A read in progress when reset is asserted SHALL be dropped, and readdatavalid SHALL be 0 in the following cycle.

Structure
REQ-029 Package soc_sysinfo_pkg SHALL hold the word-address constants, the CTRL bit positions and the INFO field positions.
REQ-030 Sub-module soc_sysinfo_ctr SHALL implement the CNT_W counter with enable, clear and shadow-latch inputs; decode, tick and interrupt logic SHALL remain in the top.

Verification
REQ-031 Scenario: after reset, read addr 0, 1 and 2 with defaults -> 0x63797378, 0x0, 0x00010230, each with readdatavalid 1 cycle after read.
REQ-032 Scenario: write SCRATCH0=0xDEADBEEF with byteenable=4'b0011, then read -> 0x0000BEEF; read addr 15 -> 0; write addr 0 then read -> ID unchanged.
REQ-033 Scenario: force counter to 0x0000_FFFF_FFFF, read CNT_LO -> 0xFFFFFFFF, wait 5 cycles, read CNT_HI -> 0x0 (shadow, not 0x1).
REQ-034 Scenario: CTRL=0x3, PERIOD=4 -> STATUS bit0 sets every 4 cycles and irq rises 1 cycle after; write STATUS=1 in a set cycle -> bit stays 1.
REQ-035 Scenario: write CTRL=0x5 -> counter reads near 0 on the next CNT_LO read; write CTRL=0x0 -> two CNT_LO reads 10 cycles apart return equal values.
REQ-036 Scenario: assert reset_n=0 in the cycle after read -> readdatavalid=0, CTRL reads 0x1 and irq=0 after reset is released.
